// File: rtl/pc_seq_unit.sv
// Registered program-counter sequencer: owns the PC, resolves branch/jump/return
// flow by fixed priority and keeps a circular return-address stack for jal/ret.
module pc_seq_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        br_op,
  input  logic              zero,
  input  logic              neg,
  input  logic              j,
  input  logic              jal,
  input  logic              jr,
  input  logic              ret,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pc_src,
  output logic              flush,
  output logic [ADDR_W-1:0] link_addr,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic              misalign
);

  localparam int                PTR_W   = $clog2(RAS_DEPTH);
  localparam int                CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JAL,
    SEL_JR,
    SEL_RET
  } sel_e;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];

  sel_e              sel;
  logic              br_taken;
  logic              push;
  logic [PTR_W-1:0]  top_inc;
  logic [PTR_W-1:0]  top_dec;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] ind_raw;
  logic [ADDR_W-1:0] next_pc;

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign link_addr = pc_plus4;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);
  assign flush     = flush_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

  // Pointer wraps explicitly so non-power-of-two depths stay inside the array.
  assign top_inc = (top_q == PTR_MAX) ? '0 : top_q + PTR_W'(1);
  assign top_dec = (top_q == '0) ? PTR_MAX : top_q - PTR_W'(1);

  assign br_off    = {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign br_target = pc_plus4 + br_off;
  assign j_target  = {pc_plus4[ADDR_W-1:28], imm26, 2'b00};
  assign ind_raw   = (sel == SEL_RET && !ras_empty) ? ras_mem_q[top_q] : rs_val;

  always_comb begin
    br_taken = 1'b0;
    case (br_op)
      3'b001:  br_taken = zero;
      3'b010:  br_taken = !zero;
      3'b011:  br_taken = zero | neg;
      3'b100:  br_taken = !zero & !neg;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    sel = SEL_SEQ;
    if (ret)           sel = SEL_RET;
    else if (jr)       sel = SEL_JR;
    else if (jal)      sel = SEL_JAL;
    else if (j)        sel = SEL_J;
    else if (br_taken) sel = SEL_BR;
  end

  always_comb begin
    next_pc  = pc_plus4;
    pc_src   = 1'b0;
    misalign = 1'b0;
    case (sel)
      SEL_BR: begin
        next_pc = br_target;
        pc_src  = 1'b1;
      end
      SEL_J, SEL_JAL: begin
        next_pc = j_target;
        pc_src  = 1'b1;
      end
      SEL_JR, SEL_RET: begin
        next_pc  = {ind_raw[ADDR_W-1:2], 2'b00};
        pc_src   = 1'b1;
        misalign = (ind_raw[1:0] != 2'b00);
      end
      default: begin
        next_pc = pc_plus4;
      end
    endcase
  end

  // A full stack overwrites its oldest slot; an empty pop leaves state alone.
  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    push    = 1'b0;
    if (!stall) begin
      pc_d    = next_pc;
      flush_d = pc_src;
      if (sel == SEL_JAL) begin
        push  = 1'b1;
        top_d = top_inc;
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_W'(1);
      end else if (sel == SEL_RET) begin
        if (cnt_q == '0) begin
          unf_d = 1'b1;
        end else begin
          top_d = top_dec;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      top_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) ras_mem_q[top_inc] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed scenarios followed by random traffic, all
// compared against a queue-based model of PC flow and the return stack.
module tb_pc_seq_unit;

  localparam int          ADDR_W    = 32;
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam int          RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, stall, zero, neg, j, jal, jr, ret;
  logic [2:0]  br_op;
  logic [25:0] imm26;
  logic [31:0] rs_val;
  logic [31:0] pc, pc_plus4, link_addr;
  logic        pc_src, flush, ras_empty, ras_full, ras_ovf, ras_unf, misalign;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] mPc;
  logic [31:0] mRas [$];
  logic        mFlush, mOvf, mUnf;
  bit          mValid = 1'b0;
  logic        sawPcSrc, sawMisalign;

  logic [25:0] jalImm [5];
  logic [31:0] retExp [4];

  pc_seq_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .br_op    (br_op),
    .zero     (zero),
    .neg      (neg),
    .j        (j),
    .jal      (jal),
    .jr       (jr),
    .ret      (ret),
    .imm26    (imm26),
    .rs_val   (rs_val),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .pc_src   (pc_src),
    .flush    (flush),
    .link_addr(link_addr),
    .ras_empty(ras_empty),
    .ras_full (ras_full),
    .ras_ovf  (ras_ovf),
    .ras_unf  (ras_unf),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clearIn();
    rst = 0; stall = 0; zero = 0; neg = 0; j = 0; jal = 0; jr = 0; ret = 0;
    br_op = 3'b000; imm26 = '0; rs_val = '0;
  endtask

  // One clock: compare combinational and registered outputs mid-cycle against
  // the model, then advance the model with the inputs presented this cycle.
  task automatic step();
    logic [31:0] plus4, raw, tgt;
    bit          taken, redirect, mis;
    int          kind;
    int          off;
    @(negedge clk);
    plus4 = mPc + 32'd4;
    case (br_op)
      3'b001:  taken = zero;
      3'b010:  taken = !zero;
      3'b011:  taken = zero || neg;
      3'b100:  taken = !zero && !neg;
      default: taken = 1'b0;
    endcase
    if (ret)        kind = 5;
    else if (jr)    kind = 4;
    else if (jal)   kind = 3;
    else if (j)     kind = 2;
    else if (taken) kind = 1;
    else            kind = 0;
    raw = rs_val;
    if (kind == 5 && mRas.size() > 0) raw = mRas[$];
    off = int'($signed(imm26[15:0]));
    case (kind)
      5, 4:    tgt = raw & ~32'd3;
      3, 2:    tgt = (plus4 & 32'hF000_0000) | (32'(imm26) * 4);
      1:       tgt = plus4 + 32'(off * 4);
      default: tgt = plus4;
    endcase
    redirect = (kind != 0);
    mis      = (kind >= 4) && (raw % 4 != 0);
    sawPcSrc    = pc_src;
    sawMisalign = misalign;
    if (mValid) begin
      check("pc", pc, mPc);
      check("pc_plus4", pc_plus4, plus4);
      check("link_addr", link_addr, plus4);
      check("pc_src", pc_src, redirect);
      check("misalign", misalign, mis);
      check("ras_empty", ras_empty, mRas.size() == 0);
      check("ras_full", ras_full, mRas.size() == RAS_DEPTH);
      check("flush", flush, mFlush);
      check("ras_ovf", ras_ovf, mOvf);
      check("ras_unf", ras_unf, mUnf);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mPc = RESET_PC; mRas.delete(); mFlush = 0; mOvf = 0; mUnf = 0; mValid = 1;
    end else if (stall) begin
      mFlush = 0; mOvf = 0; mUnf = 0;
    end else begin
      mPc = tgt; mFlush = redirect; mOvf = 0; mUnf = 0;
      if (kind == 3) begin
        if (mRas.size() == RAS_DEPTH) begin
          void'(mRas.pop_front());
          mOvf = 1;
        end
        mRas.push_back(plus4);
      end else if (kind == 5) begin
        if (mRas.size() > 0) void'(mRas.pop_back());
        else                 mUnf = 1;
      end
    end
  endtask

  initial begin
    jalImm = '{26'h200, 26'h300, 26'h500, 26'h600, 26'h700};
    retExp = '{32'h1804, 32'h1404, 32'h0C04, 32'h0804};

    clearIn();
    rst = 1; step(); rst = 0;
    check("reset_pc", pc, RESET_PC);
    check("reset_empty", ras_empty, 1'b1);
    repeat (3) step();
    check("seq_pc", pc, 32'h0040_000C);
    stall = 1; repeat (2) step(); stall = 0;
    check("stall_pc", pc, 32'h0040_000C);

    jr = 1; rs_val = 32'h100; step(); jr = 0;
    check("jr_pc", pc, 32'h100);
    br_op = 3'b001; zero = 1; imm26 = 26'h000FFFC; step();
    check("beq_src", sawPcSrc, 1'b1);
    check("beq_pc", pc, 32'hF4);
    check("beq_flush", flush, 1'b1);
    br_op = 3'b000; zero = 0; step();
    check("flush_once", flush, 1'b0);
    jr = 1; rs_val = 32'h100; step(); jr = 0;
    br_op = 3'b010; zero = 1; imm26 = 26'h000FFFC; step();
    check("bne_src", sawPcSrc, 1'b0);
    check("bne_pc", pc, 32'h104);
    br_op = 3'b000; zero = 0;

    jr = 1; rs_val = 32'h200; step(); jr = 0;
    jal = 1; imm26 = 26'h40; step(); jal = 0;
    check("jal_pc", pc, 32'h100);
    check("jal_not_empty", ras_empty, 1'b0);
    ret = 1; step(); ret = 0;
    check("ret_pc", pc, 32'h204);
    check("ret_empty", ras_empty, 1'b1);

    jr = 1; rs_val = 32'h1000; step(); jr = 0;
    for (int k = 0; k < 5; k++) begin
      jal = 1; imm26 = jalImm[k]; step();
      check("ovf_pulse", ras_ovf, k == 4);
    end
    jal = 0;
    check("ovf_full", ras_full, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ret = 1; rs_val = 32'h0; step();
      check("ret_order", pc, retExp[k]);
    end
    rs_val = 32'h300; step(); ret = 0;
    check("unf_pc", pc, 32'h300);
    check("unf_pulse", ras_unf, 1'b1);

    jal = 1; imm26 = 26'h400; step(); jal = 0;
    check("push_one", ras_empty, 1'b0);
    ret = 1; jal = 1; br_op = 3'b001; zero = 1; rs_val = 32'h5550; step();
    check("prio_pc", pc, 32'h304);
    check("prio_pop", ras_empty, 1'b1);
    clearIn();
    jr = 1; rs_val = 32'h1002; step(); jr = 0;
    check("mis_flag", sawMisalign, 1'b1);
    check("mis_pc", pc, 32'h1000);

    zero = 0; neg = 1; imm26 = 26'h4;
    br_op = 3'b100; step();
    check("bgtz_src", sawPcSrc, 1'b0);
    check("bgtz_pc", pc, 32'h1004);
    br_op = 3'b011; step();
    check("blez_src", sawPcSrc, 1'b1);
    check("blez_pc", pc, 32'h1018);
    clearIn();
    j = 1; imm26 = 26'h123; rst = 1; step(); clearIn();
    check("rst_j_pc", pc, RESET_PC);
    check("rst_j_flush", flush, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(63) == 0);
      stall  = ($urandom_range(7) == 0);
      ret    = ($urandom_range(6) == 0);
      jr     = ($urandom_range(9) == 0);
      jal    = ($urandom_range(4) == 0);
      j      = ($urandom_range(9) == 0);
      br_op  = 3'($urandom_range(7));
      zero   = 1'($urandom);
      neg    = 1'($urandom);
      imm26  = 26'($urandom);
      rs_val = $urandom;
      if ($urandom_range(1) == 1) rs_val[1:0] = 2'b00;
      step();
    end
    clearIn();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter sequencer for the MIPS processor. It owns the PC register and computes the next fetch address for sequential, branch, jump, jump-and-link, jump-register and return flow. It includes a hardware return-address stack (RAS) and supports stall and redirect signalling. It sits between the control/ALU stage and instruction fetch and is the registered successor to the combinational next-PC logic.

## Interface
- ADDR_W, 32, PC width; legal range 32..64.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.
- RAS_DEPTH, 4, return-address stack entries; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  holds the PC and the RAS for this cycle.
- br_op  in  3  000 none, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ; 101..111 treated as none.
- zero  in  1  ALU result == 0.
- neg  in  1  ALU result sign bit.
- j  in  1  jump.
- jal  in  1  jump and link; pushes the return address.
- jr  in  1  jump to rs_val; the RAS is untouched.
- ret  in  1  return; pops the RAS.
- imm26  in  26  instruction immediate. Bits [15:0] are the branch offset.
- rs_val  in  ADDR_W  register operand for jr, and the fallback for ret.
- pc  out  ADDR_W  current fetch address.
- pc_plus4  out  ADDR_W  pc + 4, wrapping modulo 2^ADDR_W.
- pc_src  out  1  redirect taken this cycle (combinational).
- flush  out  1  registered pulse, high in the cycle after a committed redirect.
- link_addr  out  ADDR_W  equal to pc_plus4; used as the write-back value for jal.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_ovf  out  1  single-cycle pulse: a push occurred while full.
- ras_unf  out  1  single-cycle pulse: a pop occurred while empty.
- misalign  out  1  combinational: the jr or ret target has bits [1:0] != 0.

## Operation
- Targets:
  - Branch: pc_plus4 + (sign-extend(imm26[15:0]) << 2), computed in ADDR_W bits and wrapping.
  - Jump: {pc_plus4[ADDR_W-1:28], imm26, 2'b00}.
  - jr: rs_val.
  - ret: RAS top if not empty, otherwise rs_val.
- Branch conditions:
  - BEQ: zero.
  - BNE: !zero.
  - BLEZ: zero | neg.
  - BGTZ: !zero & !neg.
- Priority when several inputs are asserted: ret > jr > jal > j > branch > sequential. Only the winner acts; losers have no side effects. For example, jal loses to jr and then does not push.
- pc_src is high when the winner is ret, jr, jal, j, or a branch whose condition is true.
- Next PC is the winner's target; with no redirect it is pc_plus4. jr and ret targets are loaded with bits [1:0] cleared, and misalign is raised.
- RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH).
  - Push (jal, not stalled): writes pc_plus4 at top+1 and increments count. When full, the oldest entry is overwritten, count stays at RAS_DEPTH and ras_ovf pulses.
  - Pop (ret, not stalled): reads the top entry, decrements the pointer and decrements count. When empty, rs_val is used, state is unchanged and ras_unf pulses.
  - Push and pop cannot occur in the same cycle, because of the priority order.
- Stall: pc, RAS, count and pointers hold. flush, ras_ovf and ras_unf are 0 next cycle. pc_src and misalign still reflect the inputs combinationally.

## Timing
- Reset (rst high at an edge):
  - pc = RESET_PC.
  - RAS count = 0 and pointer = 0; entry contents are don't-care.
  - flush = 0, ras_ovf = 0, ras_unf = 0.
  - Reset has priority over stall and every control input. A reset mid-sequence discards pending redirects.
- PC update: one edge. The inputs sampled at edge N determine pc after edge N. pc_src and all target logic are combinational from the current pc and inputs.
- flush: high for exactly one cycle after an edge where pc_src = 1 and stall = 0. It is never asserted across a stall.
- ras_ovf and ras_unf: registered, high for the one cycle after the offending edge.
- The ras_empty and ras_full flags reflect the registered count.

## Test plan
- Reset with RESET_PC = 0x00400000 → pc = 0x00400000 and ras_empty = 1. After 3 unstalled cycles pc = 0x0040000C. With stall high for 2 cycles pc holds at 0x0040000C.
- At pc = 0x100: BEQ, zero = 1, imm16 = 0xFFFC → pc_src = 1, next pc = 0xF4, flush = 1 for one cycle. Same setup with BNE → pc_src = 0, next pc = 0x104.
- At pc = 0x200: jal with imm26 = 0x0000040 → next pc = 0x100 and RAS top = 0x204. Then ret → next pc = 0x204 and ras_empty = 1.
- RAS_DEPTH = 4: five jal pushes with return addresses A1..A5 → ras_ovf pulses once, on the fifth. Four rets then yield A5, A4, A3, A2. A fifth ret with rs_val = 0x300 → pc = 0x300 and ras_unf pulses.
- Simultaneous inputs: ret, jal and BEQ (taken) together → ret wins, no push occurs, and count decrements by one. jr with rs_val = 0x1002 → pc = 0x1000 and misalign = 1.
- BLEZ/BGTZ: with zero = 0 and neg = 1, BLEZ is taken and BGTZ is not. Assert rst in the same cycle as a taken jump → pc = RESET_PC and flush = 0.
